uart_bus_master: RTL and testbench

- Upstream driver for the UART chip's parallel register bus: chip select, 3-bit address, read/write line, bidirectional 8-bit data.
- Converts a single-beat valid/ready request stream from the host-side logic into correctly timed bus cycles: setup, strobe, hold.
- Returns read data or a write completion on a one-cycle response pulse.
- Registers the UART's active-low interrupt line for the host.
- The hold phase always returns chip select high, so the UART's posedge detectors re-arm between back-to-back accesses.

---
 rtl/uart_bus_pkg.sv | 23 ++
 rtl/uart_bus_master.sv | 127 ++++++++++++
 tb/tb_uart_bus_master.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_pkg.sv
// Shared types for the UART parallel bus master.
// Phase encoding, request bundle and read/write line levels.
package uart_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } phase_e;

  typedef struct packed {
    logic       write;
    logic [2:0] addr;
    logic [7:0] wdata;
  } bus_req_t;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam int   CNT_W = 4;

endpackage

// File: rtl/uart_bus_master.sv
// Drives the UART register bus: setup, strobe and hold phases per access.
// Single-beat requests in, one-cycle completion pulse out.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [2:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       chip_sel_n_o,
  output logic [2:0] address_o,
  output logic       read_write_o,
  inout  wire  [7:0] data_io,
  input  logic       ireq_n_i,
  output logic       irq_o
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
    $error("SETUP_CYCLES out of range 1..15");
  end
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("STROBE_CYCLES out of range 1..15");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("HOLD_CYCLES out of range 1..15");
  end

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bus_req_t         req_q, req_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             drive_en;
  logic             in_xfer;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    irq_d   = !ireq_n_i;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          req_d.write = req_write_i;
          req_d.addr  = req_addr_i;
          req_d.wdata = req_wdata_i;
          state_d     = SETUP;
          cnt_d       = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          if (!req_q.write) rdata_d = data_io;
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          if (req_q.write) rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write data is only driven while read_write_o is low.
  always_comb begin
    in_xfer      = (state_q == SETUP) || (state_q == STROBE)
                || (state_q == HOLD);
    drive_en     = in_xfer && req_q.write;
    req_ready_o  = (state_q == IDLE) && rst_n_i;
    chip_sel_n_o = (state_q != STROBE);
    read_write_o = (in_xfer && req_q.write) ? WRITE : READ;
    rsp_valid_o  = (state_q == RESP);
    address_o    = req_q.addr;
    rsp_rdata_o  = rdata_q;
    irq_o        = irq_q;
  end

  assign data_io = drive_en ? req_q.wdata : 8'bz;

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: two parameter sets, random traffic,
// transaction-timeline reference model and a UART-side bus model.
module tb_uart_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit done_q [2];

  task automatic chk(input int g, input string nm,
                     input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %0h expected %0h",
               g, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int S   = g ? 3 : 1;
    localparam int T   = g ? 1 : 2;
    localparam int H   = g ? 2 : 1;
    localparam int L   = S + T + H;
    localparam int LAT = g ? 7 : 5;
    localparam int CSW = g ? 1 : 2;

    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [2:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       ireq_n = 1'b1;
    logic [7:0] bus_val = '0;
    logic       req_ready, rsp_valid, cs_n, rw, irq;
    logic [7:0] rsp_rdata;
    logic [2:0] address;
    wire  [7:0] data_bus;

    uart_bus_master #(
      .SETUP_CYCLES (S),
      .STROBE_CYCLES(T),
      .HOLD_CYCLES  (H)
    ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_write_i (req_write),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .chip_sel_n_o(cs_n),
      .address_o   (address),
      .read_write_o(rw),
      .data_io     (data_bus),
      .ireq_n_i    (ireq_n),
      .irq_o       (irq)
    );

    // Model: cycle k of the current transaction (accept cycle = 0)
    bit         m_act = 1'b0;
    int         m_k = 0;
    bit         m_w = 1'b0;
    logic [2:0] m_addr = '0;
    logic [7:0] m_wd = '0;
    logic [7:0] m_bv = '0;
    logic [7:0] m_rd = '0;
    bit         m_irq = 1'b0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         cs_run = 0;

    wire       m_drv = m_act && (m_k <= L) && m_w;
    wire [7:0] uart_val = m_act ? m_bv : bus_val;
    assign data_bus = m_drv ? 8'bz : uart_val;

    always @(posedge clk) begin
      #1;
      if ($urandom_range(0, 3) == 0) ireq_n = ~ireq_n;
    end

    always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
        m_act  = 1'b0;
        m_addr = '0;
        m_rd   = '0;
        m_irq  = 1'b0;
        cs_run = 0;
        chk(g, "rst_ready", int'(req_ready), 0);
        chk(g, "rst_cs_n", int'(cs_n), 1);
        chk(g, "rst_rw", int'(rw), 1);
        chk(g, "rst_addr", int'(address), 0);
        chk(g, "rst_rsp_valid", int'(rsp_valid), 0);
        chk(g, "rst_rdata", int'(rsp_rdata), 0);
        chk(g, "rst_irq", int'(irq), 0);
      end else begin
        chk(g, "ready", int'(req_ready), int'(!m_act));
        chk(g, "cs_n", int'(cs_n),
            int'(!(m_act && m_k > S && m_k <= S + T)));
        chk(g, "rw", int'(rw),
            int'(!(m_act && m_k <= L && m_w)));
        chk(g, "rsp_valid", int'(rsp_valid),
            int'(m_act && m_k == L + 1));
        chk(g, "addr", int'(address), int'(m_addr));
        chk(g, "rdata", int'(rsp_rdata), int'(m_rd));
        chk(g, "irq", int'(irq), int'(m_irq));
        chk(g, "data_bus", int'(data_bus),
            int'(m_drv ? m_wd : uart_val));
        if (req_valid && req_ready) acc_cyc = cyc;
        if (rsp_valid) chk(g, "latency", cyc - acc_cyc, LAT);
        if (!cs_n) cs_run++;
        else if (cs_run > 0) begin
          chk(g, "cs_width", cs_run, CSW);
          cs_run = 0;
        end
        m_irq = !ireq_n;
        if (m_act) begin
          if (m_k == L + 1) m_act = 1'b0;
          else begin
            m_k++;
            if (m_k == S + T + 1 && !m_w) m_rd = m_bv;
            if (m_k == L + 1 && m_w) m_rd = '0;
          end
        end else if (req_valid) begin
          m_act  = 1'b1;
          m_k    = 1;
          m_w    = req_write;
          m_addr = req_addr;
          m_wd   = req_wdata;
          m_bv   = bus_val;
        end
      end
    end

    task automatic send(input bit w, input logic [2:0] a,
                        input logic [7:0] d);
      int n = 0;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      while (!req_ready && n < 50) begin
        n++;
        @(negedge clk);
      end
      if (n >= 50) chk(g, "accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = 3'($urandom);
      req_wdata = 8'($urandom);
    endtask

    task automatic wait_rsp(input logic [7:0] exp);
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid && n < 50);
      if (!rsp_valid) chk(g, "rsp_timeout", 0, 1);
      else chk(g, "rdata_lit", int'(rsp_rdata), int'(exp));
    endtask

    initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      send(1'b1, 3'h2, 8'hA5);
      wait_rsp(8'h00);
      bus_val = 8'h3C;
      send(1'b0, 3'h0, 8'h00);
      wait_rsp(8'h3C);
      @(posedge clk);
      #1;
      send(1'b1, 3'h1, 8'h11);
      send(1'b1, 3'h4, 8'h22);
      send(1'b1, 3'h7, 8'h33);
      wait_rsp(8'h00);
      repeat (4) @(posedge clk);
      #1;
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        bus_val = 8'($urandom);
        send(1'($urandom), 3'($urandom), 8'($urandom));
      end
      repeat (12) @(posedge clk);
      #1;
      send(1'b1, 3'h5, 8'h5A);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (cs_n && n < 50);
      if (cs_n) chk(g, "strobe_timeout", 0, 1);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bus_val = 8'h81;
      send(1'b0, 3'h3, 8'h00);
      wait_rsp(8'h81);
      repeat (4) @(posedge clk);
      done_q[g] = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(done_q[0] && done_q[1]) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 20000) chk(-1, "global_timeout", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
